bu_stage_sequencer: RTL and testbench

Schedules a full N-point NTT (Cooley-Tukey) or INTT (Gentleman-Sande) pass over a dual-bank coefficient memory and keeps one butterfly unit fed. Generates paired read addresses and zeta indices, drives the butterfly mode, and tracks the butterfly pipeline so results are written back in place at the matching addresses. It sits between the polynomial RAM / zeta ROM and the butterfly datapath. The butterfly data path is wired externally; this block carries control only.

---
 rtl/bu_stage_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_bu_stage_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bu_stage_sequencer.sv
// NTT/INTT stage sequencer: walks every butterfly pair of an N-point transform,
// issues read addresses and zeta indices one pair per cycle, and delays the pair
// addresses through a shift register so the butterfly results are written back in place.
module bu_stage_sequencer #(
   parameter int unsigned N      = 256,
   parameter int unsigned LOG2N  = $clog2(N),
   parameter int unsigned BU_LAT = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic             mode_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             bu_mode_o,
   output logic             rd_en_o,
   output logic [LOG2N-1:0] rd_addr_a_o,
   output logic [LOG2N-1:0] rd_addr_b_o,
   output logic [LOG2N-1:0] zeta_idx_o,
   output logic             wr_en_o,
   output logic [LOG2N-1:0] wr_addr_a_o,
   output logic [LOG2N-1:0] wr_addr_b_o
);

   // One cycle of memory read latency plus the butterfly latency.
   localparam int unsigned Depth  = 1 + BU_LAT;
   localparam int unsigned DrainW = $clog2(Depth);

   localparam logic [LOG2N-1:0] One       = LOG2N'(1);
   localparam logic [LOG2N-1:0] NMinus1   = LOG2N'(N - 1);
   localparam logic [LOG2N-1:0] LastStage = LOG2N'(LOG2N - 1);

   typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

   state_e state_q, state_d;

   logic              mode_q, mode_d;
   logic [LOG2N-1:0]  stage_q, stage_d;
   logic [LOG2N-1:0]  j_q, j_d;
   logic [LOG2N-1:0]  g_q, g_d;
   logic [LOG2N-1:0]  k_q, k_d;
   logic [DrainW-1:0] drain_q, drain_d;

   logic             pipe_v_q [Depth];
   logic [LOG2N-1:0] pipe_a_q [Depth];
   logic [LOG2N-1:0] pipe_b_q [Depth];

   logic [LOG2N-1:0] len;
   logic [LOG2N-1:0] j_plus_len;
   logic             issue;
   logic             group_end;
   logic             last_pair;
   logic             last_stage;
   logic             drain_end;

   // Loop-position decode: butterfly span for this stage and end-of-group/stage flags.
   always_comb begin
      len        = mode_q ? LOG2N'(N >> (stage_q + 1)) : LOG2N'(1 << stage_q);
      j_plus_len = j_q + len;
      issue      = (state_q == StIssue);
      group_end  = ((j_q - g_q) == (len - One));
      // The final pair of any stage always ends at address N-1.
      last_pair  = (j_plus_len == NMinus1);
      last_stage = (stage_q == LastStage);
      drain_end  = (drain_q == DrainW'(BU_LAT));
   end

   // FSM state register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start_i) state_d = StIssue;
         StIssue: if (last_pair) state_d = StDrain;
         StDrain: if (drain_end) state_d = last_stage ? StDone : StIssue;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // FSM outputs; read-side fields are forced to 0 outside ISSUE.
   always_comb begin
      busy_o      = (state_q != StIdle);
      done_o      = (state_q == StDone);
      bu_mode_o   = mode_q;
      rd_en_o     = issue;
      rd_addr_a_o = issue ? j_q : '0;
      rd_addr_b_o = issue ? j_plus_len : '0;
      zeta_idx_o  = issue ? k_q : '0;
      wr_en_o     = pipe_v_q[Depth-1];
      wr_addr_a_o = pipe_v_q[Depth-1] ? pipe_a_q[Depth-1] : '0;
      wr_addr_b_o = pipe_v_q[Depth-1] ? pipe_b_q[Depth-1] : '0;
   end

   // Next values of the stage / group / pair / zeta / drain counters.
   always_comb begin
      mode_d  = mode_q;
      stage_d = stage_q;
      j_d     = j_q;
      g_d     = g_q;
      k_d     = k_q;
      drain_d = drain_q;
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               mode_d  = mode_i;
               stage_d = '0;
               j_d     = '0;
               g_d     = '0;
               k_d     = mode_i ? One : NMinus1;
               drain_d = '0;
            end
         end
         StIssue: begin
            if (group_end) begin
               // Wraps to 0 after the last group, ready for the next stage.
               g_d = g_q + (len << 1);
               j_d = g_q + (len << 1);
               // k runs on across stages; skip the step after the very last group.
               if (!(last_pair && last_stage)) begin
                  k_d = mode_q ? (k_q + One) : (k_q - One);
               end
            end else begin
               j_d = j_q + One;
            end
            if (last_pair) drain_d = '0;
         end
         StDrain: begin
            drain_d = drain_q + DrainW'(1);
            if (drain_end && !last_stage) stage_d = stage_q + One;
         end
         default: ;
      endcase
   end

   // Counter registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mode_q  <= 1'b0;
         stage_q <= '0;
         j_q     <= '0;
         g_q     <= '0;
         k_q     <= '0;
         drain_q <= '0;
      end else begin
         mode_q  <= mode_d;
         stage_q <= stage_d;
         j_q     <= j_d;
         g_q     <= g_d;
         k_q     <= k_d;
         drain_q <= drain_d;
      end
   end

   // Write-back shift register carrying {valid, addr_a, addr_b} of each issued pair.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < Depth; i++) begin
            pipe_v_q[i] <= 1'b0;
            pipe_a_q[i] <= '0;
            pipe_b_q[i] <= '0;
         end
      end else begin
         pipe_v_q[0] <= issue;
         pipe_a_q[0] <= issue ? j_q : '0;
         pipe_b_q[0] <= issue ? j_plus_len : '0;
         for (int unsigned i = 1; i < Depth; i++) begin
            pipe_v_q[i] <= pipe_v_q[i-1];
            pipe_a_q[i] <= pipe_a_q[i-1];
            pipe_b_q[i] <= pipe_b_q[i-1];
         end
      end
   end

endmodule

// File: tb/tb_bu_stage_sequencer.sv
// Bench for bu_stage_sequencer (N=8, BU_LAT=2): per-cycle schedule compare against a
// loop-nest model, plus a behavioural memory/butterfly checked against a reference NTT.
module tb_bu_stage_sequencer;

   localparam int N      = 8;
   localparam int LOG2N  = 3;
   localparam int BU_LAT = 2;
   localparam int Q      = 3329;
   localparam int Lat    = 1 + BU_LAT;
   localparam int DoneC  = LOG2N * (N / 2 + Lat) + 1;
   localparam int Span   = DoneC + 3;

   logic             clk;
   logic             rst_ni;
   logic             start_i;
   logic             mode_i;
   logic             busy_o;
   logic             done_o;
   logic             bu_mode_o;
   logic             rd_en_o;
   logic [LOG2N-1:0] rd_addr_a_o;
   logic [LOG2N-1:0] rd_addr_b_o;
   logic [LOG2N-1:0] zeta_idx_o;
   logic             wr_en_o;
   logic [LOG2N-1:0] wr_addr_a_o;
   logic [LOG2N-1:0] wr_addr_b_o;

   bu_stage_sequencer #(
      .N      (N),
      .LOG2N  (LOG2N),
      .BU_LAT (BU_LAT)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_ni),
      .start_i     (start_i),
      .mode_i      (mode_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .bu_mode_o   (bu_mode_o),
      .rd_en_o     (rd_en_o),
      .rd_addr_a_o (rd_addr_a_o),
      .rd_addr_b_o (rd_addr_b_o),
      .zeta_idx_o  (zeta_idx_o),
      .wr_en_o     (wr_en_o),
      .wr_addr_a_o (wr_addr_a_o),
      .wr_addr_b_o (wr_addr_b_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int c;
      int u;
      int t;
   } wb_t;

   int  n_pass;
   int  n_total;
   int  mem   [N];
   int  refm  [N];
   int  ztab  [N];
   bit  exp_rd [Span];
   int  exp_a  [Span];
   int  exp_b  [Span];
   int  exp_k  [Span];
   bit  cur_mode;
   wb_t dq [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_rd_en"}, 32'(rd_en_o), 0);
      check({tag, "_wr_en"}, 32'(wr_en_o), 0);
      check({tag, "_busy"}, 32'(busy_o), 0);
      check({tag, "_done"}, 32'(done_o), 0);
      check({tag, "_bu_mode"}, 32'(bu_mode_o), 0);
      check({tag, "_rd_a"}, 32'(rd_addr_a_o), 0);
      check({tag, "_rd_b"}, 32'(rd_addr_b_o), 0);
      check({tag, "_zeta"}, 32'(zeta_idx_o), 0);
      check({tag, "_wr_a"}, 32'(wr_addr_a_o), 0);
      check({tag, "_wr_b"}, 32'(wr_addr_b_o), 0);
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         check("idle_wr_en", 32'(wr_en_o), 0);
         check("idle_rd_en", 32'(rd_en_o), 0);
         check("idle_busy", 32'(busy_o), 0);
         step();
      end
   endtask

   // Expected issue schedule by cycle, straight from the transform's loop nest.
   task automatic build_expect(input bit mode);
      int c;
      int k;
      int len;
      for (int i = 0; i < Span; i++) begin
         exp_rd[i] = 1'b0;
         exp_a[i]  = 0;
         exp_b[i]  = 0;
         exp_k[i]  = 0;
      end
      c = 1;
      k = mode ? 1 : N - 1;
      for (int s = 0; s < LOG2N; s++) begin
         len = mode ? (N >> (s + 1)) : (1 << s);
         for (int g = 0; g < N; g += 2 * len) begin
            for (int j = g; j < g + len; j++) begin
               exp_rd[c] = 1'b1;
               exp_a[c]  = j;
               exp_b[c]  = j + len;
               exp_k[c]  = k;
               c++;
            end
            k = mode ? k + 1 : k - 1;
         end
         c += Lat;
      end
   endtask

   task automatic ref_ntt(input bit mode);
      int k;
      int len;
      int z;
      int u;
      int t;
      k = mode ? 1 : N - 1;
      for (int s = 0; s < LOG2N; s++) begin
         len = mode ? (N >> (s + 1)) : (1 << s);
         for (int g = 0; g < N; g += 2 * len) begin
            z = ztab[k];
            k = mode ? k + 1 : k - 1;
            for (int j = g; j < g + len; j++) begin
               u = refm[j];
               if (mode) begin
                  t = (refm[j + len] * z) % Q;
                  refm[j]       = (u + t) % Q;
                  refm[j + len] = (u - t + Q) % Q;
               end else begin
                  refm[j]       = (u + refm[j + len]) % Q;
                  refm[j + len] = (((u - refm[j + len] + Q) % Q) * z) % Q;
               end
            end
         end
      end
   endtask

   task automatic init_data();
      for (int i = 0; i < N; i++) begin
         mem[i]  = int'($urandom_range(Q - 1, 0));
         refm[i] = mem[i];
      end
   endtask

   // One pass with start at local cycle 0; extra start pulses at sa/sb; optional reset at rst_at.
   task automatic run_pass(input bit mode, input int sa, input int sb, input int rst_at);
      int  u;
      int  v;
      int  z;
      int  t;
      bit  exp_wr;
      wb_t w;
      build_expect(mode);
      ref_ntt(mode);
      dq.delete();
      for (int c = 0; c < Span; c++) begin
         start_i = (c == 0) || (c == sa) || (c == sb);
         mode_i  = (c == 0) ? mode : 1'($urandom());
         if (c == rst_at) begin
            rst_ni = 1'b0;
            #1;
            check_all_zero("reset_mid");
            cur_mode = 1'b0;
            dq.delete();
            start_i = 1'b0;
            step();
            rst_ni = 1'b1;
            check_all_zero("reset_after");
            return;
         end
         exp_wr = (c >= Lat) && exp_rd[c - Lat];
         check("rd_en", 32'(rd_en_o), 32'(exp_rd[c]));
         check("rd_a", 32'(rd_addr_a_o), exp_a[c]);
         check("rd_b", 32'(rd_addr_b_o), exp_b[c]);
         check("zeta", 32'(zeta_idx_o), exp_k[c]);
         check("wr_en", 32'(wr_en_o), 32'(exp_wr));
         check("wr_a", 32'(wr_addr_a_o), exp_wr ? exp_a[c - Lat] : 0);
         check("wr_b", 32'(wr_addr_b_o), exp_wr ? exp_b[c - Lat] : 0);
         check("busy", 32'(busy_o), 32'((c >= 1) && (c <= DoneC)));
         check("done", 32'(done_o), 32'(c == DoneC));
         check("bu_mode", 32'(bu_mode_o), 32'((c == 0) ? cur_mode : mode));
         // Behavioural synchronous RAM + butterfly; results land at DUT write addresses.
         if (rd_en_o === 1'b1) begin
            u = mem[rd_addr_a_o];
            v = mem[rd_addr_b_o];
            z = ztab[zeta_idx_o];
            if (mode) begin
               t   = (v * z) % Q;
               w.u = (u + t) % Q;
               w.t = (u - t + Q) % Q;
            end else begin
               w.u = (u + v) % Q;
               w.t = (((u - v + Q) % Q) * z) % Q;
            end
            w.c = c;
            dq.push_back(w);
         end
         if (wr_en_o === 1'b1) begin
            if (dq.size() == 0) begin
               check("wb_orphan", 1, 0);
            end else begin
               w = dq.pop_front();
               check("wb_latency", 32'(c - w.c), Lat);
               mem[wr_addr_a_o] = w.u;
               mem[wr_addr_b_o] = w.t;
            end
         end
         step();
      end
      start_i  = 1'b0;
      cur_mode = mode;
      check("wb_leftover", 32'(dq.size()), 0);
      for (int i = 0; i < N; i++) begin
         check($sformatf("mem[%0d]", i), 32'(mem[i]), 32'(refm[i]));
      end
   endtask

   initial begin
      n_pass   = 0;
      n_total  = 0;
      cur_mode = 1'b0;
      rst_ni   = 1'b0;
      start_i  = 1'b0;
      mode_i   = 1'b0;
      for (int i = 0; i < N; i++) ztab[i] = int'($urandom_range(Q - 1, 1));
      #1;
      check_all_zero("reset");
      step();
      rst_ni = 1'b1;
      step();
      check_all_zero("post_reset");

      // Directed CT and GS passes.
      init_data();
      run_pass(1'b1, -1, -1, -1);
      init_data();
      run_pass(1'b0, -1, -1, -1);

      // Start pulses mid-pass are ignored.
      init_data();
      run_pass(1'b1, 5, 15, -1);

      // Reset mid-pass, then restart two cycles later.
      init_data();
      run_pass(1'b1, -1, -1, 9);
      idle_cycles(2);
      init_data();
      run_pass(1'b1, -1, -1, -1);
      idle_cycles(1);

      // Randomised passes with stray start pulses.
      for (int r = 0; r < 6; r++) begin
         init_data();
         run_pass(1'($urandom()), int'($urandom_range(DoneC, 1)),
                  int'($urandom_range(DoneC, 1)), -1);
         idle_cycles(int'($urandom_range(2, 0)));
      end

      // Randomised abort point, then a clean pass.
      init_data();
      run_pass(1'($urandom()), -1, -1, int'($urandom_range(DoneC, 1)));
      idle_cycles(2);
      init_data();
      run_pass(1'b0, -1, -1, -1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
